// File: rtl/axi_lite_sim_console.sv
// AXI4-Lite console and test-exit slave: per-channel byte FIFOs drained as
// ready/valid character streams, plus a sticky exit register for ending a run.
module axi_lite_sim_console #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 13
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_W-1:0]         s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_W-1:0]         s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [8*NUM_CHANNELS-1:0] char_data,
  output logic [NUM_CHANNELS-1:0]   char_valid,
  input  logic [NUM_CHANNELS-1:0]   char_ready,
  output logic                      test_done,
  output logic [31:0]               test_code,
  output logic [3:0]                test_channel
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] REG_TX      = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_EXIT    = 2'd2;
  localparam logic [7:0] NCH         = 8'(NUM_CHANNELS);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [31:0]       w_data_q, wr_data;
  logic              w_strb0_q, wr_strb0;
  logic              wr_fire, ar_fire;
  logic [7:0]        wr_chan, rd_chan;
  logic [1:0]        wr_reg, rd_reg, wr_resp, rd_resp_c;
  logic              wr_map, rd_map, exit_fire;
  logic [31:0]       rd_data_c;

  logic [7:0]                mem [NUM_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]             wptr_q [NUM_CHANNELS];
  logic [PW-1:0]             rptr_q [NUM_CHANNELS];
  logic [PW-1:0]             occ    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   ovf_q, full, empty, pop, push, push_req, ovf_set, ovf_clr;

  logic unused;
  assign unused = &{1'b0, s_axi_wstrb[3:1], wr_addr[1:0], s_axi_araddr[1:0]};

  // Write FSM: AW and W are latched independently; the write executes once both are held.
  always_comb begin
    wr_state_d    = wr_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_fire       = 1'b0;
    wr_addr       = aw_addr_q;
    wr_data       = w_data_q;
    wr_strb0      = w_strb0_q;
    case (wr_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        wr_addr       = s_axi_awaddr;
        wr_data       = s_axi_wdata;
        wr_strb0      = s_axi_wstrb[0];
        if (s_axi_awvalid && s_axi_wvalid) begin
          wr_fire    = 1'b1;
          wr_state_d = W_RESP;
        end else if (s_axi_awvalid) begin
          wr_state_d = W_HAVE_AW;
        end else if (s_axi_wvalid) begin
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        s_axi_wready = 1'b1;
        wr_data      = s_axi_wdata;
        wr_strb0     = s_axi_wstrb[0];
        if (s_axi_wvalid) begin
          wr_fire    = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        s_axi_awready = 1'b1;
        wr_addr       = s_axi_awaddr;
        if (s_axi_awvalid) begin
          wr_fire    = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      default: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
    endcase
  end

  // Read FSM: one outstanding read, response held until rready.
  always_comb begin
    rd_state_d    = rd_state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_fire       = 1'b0;
    if (rd_state_q == R_IDLE) begin
      s_axi_arready = 1'b1;
      if (s_axi_arvalid) begin
        ar_fire    = 1'b1;
        rd_state_d = R_RESP;
      end
    end else begin
      s_axi_rvalid = 1'b1;
      if (s_axi_rready) rd_state_d = R_IDLE;
    end
  end

  always_comb begin
    wr_chan   = wr_addr[11:4];
    wr_reg    = wr_addr[3:2];
    wr_map    = wr_addr[12] && (wr_chan < NCH) && (wr_reg != 2'd3);
    rd_chan   = s_axi_araddr[11:4];
    rd_reg    = s_axi_araddr[3:2];
    rd_map    = s_axi_araddr[12] && (rd_chan < NCH) && (rd_reg != 2'd3);
    exit_fire = wr_fire && wr_map && (wr_reg == REG_EXIT) && !test_done;
  end

  // Per-channel FIFO flags; a push to a full FIFO survives only if that channel pops too.
  always_comb begin
    push_req  = '0;
    push      = '0;
    ovf_set   = '0;
    ovf_clr   = '0;
    pop       = '0;
    full      = '0;
    empty     = '0;
    char_data = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      occ[c]      = wptr_q[c] - rptr_q[c];
      empty[c]    = (wptr_q[c] == rptr_q[c]);
      full[c]     = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                    (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
      pop[c]      = !empty[c] && char_ready[c];
      push_req[c] = wr_fire && wr_map && (wr_reg == REG_TX) && wr_strb0 && (wr_chan == 8'(c));
      push[c]     = push_req[c] && (!full[c] || pop[c]);
      ovf_set[c]  = push_req[c] && full[c] && !pop[c];
      ovf_clr[c]  = ar_fire && rd_map && (rd_reg == REG_STATUS) && (rd_chan == 8'(c));
      if (!empty[c]) char_data[8*c +: 8] = mem[c][rptr_q[c][AW-1:0]];
    end
    char_valid = ~empty;
  end

  always_comb begin
    wr_resp = RESP_OKAY;
    if (!wr_map) wr_resp = RESP_DECERR;
    else if (|ovf_set) wr_resp = RESP_SLVERR;
  end

  // Read mux samples FIFO state before any same-cycle push or pop lands.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (!rd_map) begin
      rd_resp_c = RESP_DECERR;
    end else if (rd_reg == REG_EXIT) begin
      rd_data_c = test_code;
    end else if (rd_reg == REG_STATUS) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (rd_chan == 8'(c)) rd_data_c = {20'b0, ovf_q[c], empty[c], full[c], 9'(occ[c])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb0_q    <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      test_done    <= 1'b0;
      test_code    <= '0;
      test_channel <= '0;
      ovf_q        <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      if (s_axi_awvalid && s_axi_awready) aw_addr_q <= s_axi_awaddr;
      if (s_axi_wvalid && s_axi_wready) begin
        w_data_q  <= s_axi_wdata;
        w_strb0_q <= s_axi_wstrb[0];
      end
      if (wr_fire) s_axi_bresp <= wr_resp;
      if (ar_fire) begin
        s_axi_rdata <= rd_data_c;
        s_axi_rresp <= rd_resp_c;
      end
      if (exit_fire) begin
        test_done    <= 1'b1;
        test_code    <= wr_data;
        test_channel <= wr_chan[3:0];
      end
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + PW'(1);
        if (pop[c]) rptr_q[c] <= rptr_q[c] + PW'(1);
        if (ovf_set[c]) ovf_q[c] <= 1'b1;
        else if (ovf_clr[c]) ovf_q[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) mem[c][wptr_q[c][AW-1:0]] <= wr_data[7:0];
    end
  end

endmodule

// File: tb/tb_axi_lite_sim_console.sv
// Scoreboard bench for axi_lite_sim_console: expected B/R responses and console
// bytes are queued at issue time and checked by independent monitors.
module tb_axi_lite_sim_console;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        resetn;
  logic [12:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, test_code;
  logic [3:0]  wstrb, test_channel;
  logic [1:0]  bresp, rresp;
  logic [15:0] char_data;
  logic [1:0]  char_valid, char_ready;
  logic        test_done;

  int checks = 0;
  int failures = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [7:0]  cq0 [$];
  logic [7:0]  cq1 [$];
  logic [1:0]  b_exp;
  logic [33:0] r_exp;
  logic [7:0]  c0_exp, c1_exp;

  always #5 clk = ~clk;

  axi_lite_sim_console #(.NUM_CHANNELS(2), .FIFO_DEPTH(16), .ADDR_W(13)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .test_done(test_done), .test_code(test_code), .test_channel(test_channel)
  );

  // Monitors: sample on the falling edge, a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (resetn && bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        failures++;
        $display("FAIL bresp_unexpected actual=%0d expected=no response", bresp);
      end else begin
        b_exp = bq.pop_front();
        if (bresp !== b_exp) begin
          failures++;
          $display("FAIL bresp actual=%0d expected=%0d", bresp, b_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL rresp_unexpected actual=0x%08h/%0d expected=no response", rdata, rresp);
      end else begin
        r_exp = rq.pop_front();
        if ({rdata, rresp} !== r_exp) begin
          failures++;
          $display("FAIL rdata_rresp actual=0x%08h/%0d expected=0x%08h/%0d",
                   rdata, rresp, r_exp[33:2], r_exp[1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && char_valid[0] && char_ready[0]) begin
      checks++;
      if (cq0.size() == 0) begin
        failures++;
        $display("FAIL char0_unexpected actual=0x%02h expected=none", char_data[7:0]);
      end else begin
        c0_exp = cq0.pop_front();
        if (char_data[7:0] !== c0_exp) begin
          failures++;
          $display("FAIL char0_data actual=0x%02h expected=0x%02h", char_data[7:0], c0_exp);
        end
      end
    end
    if (resetn && char_valid[1] && char_ready[1]) begin
      checks++;
      if (cq1.size() == 0) begin
        failures++;
        $display("FAIL char1_unexpected actual=0x%02h expected=none", char_data[15:8]);
      end else begin
        c1_exp = cq1.pop_front();
        if (char_data[15:8] !== c1_exp) begin
          failures++;
          $display("FAIL char1_data actual=0x%02h expected=0x%02h", char_data[15:8], c1_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", name);
  endtask

  task automatic hs_aw(input logic [12:0] a);
    logic hs;
    bit done = 0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      hs = awvalid && awready;
      tick();
      if (hs) begin
        awvalid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      awvalid = 1'b0;
      timeout("aw_handshake");
    end
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
    logic hs;
    bit done = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      hs = wvalid && wready;
      tick();
      if (hs) begin
        wvalid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      wvalid = 1'b0;
      timeout("w_handshake");
    end
  endtask

  // AW and W presented together; popm raises char_ready for the first edge only.
  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp, input logic [1:0] popm);
    logic aw_hs, w_hs;
    bit aw_done = 0;
    bit w_done = 0;
    bq.push_back(exp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    char_ready = char_ready | popm;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      char_ready = char_ready & ~popm;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0;
      wvalid = 1'b0;
      timeout("write_handshake");
    end
  endtask

  task automatic axi_read(input logic [12:0] a, input logic [31:0] d, input logic [1:0] exp);
    logic hs;
    bit done = 0;
    rq.push_back({d, exp});
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      if (hs) begin
        arvalid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      arvalid = 1'b0;
      timeout("ar_handshake");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (bq.size() != 0 || rq.size() != 0); i++) tick();
    if (bq.size() != 0 || rq.size() != 0) timeout("response_drain");
  endtask

  task automatic drain_chars();
    for (int i = 0; i < 100 && (cq0.size() != 0 || cq1.size() != 0); i++) tick();
    if (cq0.size() != 0 || cq1.size() != 0) timeout("char_drain");
  endtask

  initial begin
    resetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; char_ready = 2'b00;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset values
    chk("rst_readies", 32'({awready, wready, arready}), 32'h7);
    chk("rst_valids", 32'({bvalid, rvalid, bresp, rresp}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_char", 32'({char_valid, char_data}), 32'h0);
    chk("rst_test", 32'({test_done, test_channel}), 32'h0);
    chk("rst_test_code", test_code, 32'h0);

    // Basic push and drain on channel 0
    char_ready = 2'b11;
    cq0.push_back(8'h41);
    axi_write(13'h1000, 32'h41, 4'hF, OKAY, 2'b00);
    chk("bvalid_latency", 32'(bvalid), 32'h1);
    chk("char0_valid_with_bvalid", 32'(char_valid[0]), 32'h1);
    chk("char0_data_with_bvalid", 32'(char_data[7:0]), 32'h41);
    tick();
    chk("char0_single_pulse", 32'(char_valid[0]), 32'h0);
    axi_write(13'h1000, 32'h99, 4'h0, OKAY, 2'b00);
    drain();
    chk("tx_strb0_no_push", 32'(char_valid[0]), 32'h0);

    // Fill channel 1 and overflow it
    char_ready = 2'b00;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) cq1.push_back(8'(i));
      axi_write(13'h1010, 32'(i), 4'h1, (i < 16) ? OKAY : SLVERR, 2'b00);
    end
    drain();
    axi_read(13'h1014, 32'h0000_0A10, OKAY);
    axi_read(13'h1014, 32'h0000_0210, OKAY);
    drain();

    // Push into full FIFO with a same-cycle pop
    cq1.push_back(8'hAA);
    axi_write(13'h1010, 32'hAA, 4'h1, OKAY, 2'b10);
    drain();
    axi_read(13'h1014, 32'h0000_0210, OKAY);
    drain();
    char_ready = 2'b10;
    drain_chars();
    chk("char1_empty_after_drain", 32'(char_valid[1]), 32'h0);

    // Split AW/W with delayed bready
    char_ready = 2'b01;
    bready = 1'b0;
    cq0.push_back(8'h42);
    bq.push_back(OKAY);
    hs_aw(13'h1000);
    for (int k = 0; k < 3; k++) begin
      chk("bvalid_before_w", 32'(bvalid), 32'h0);
      tick();
    end
    hs_w(32'h42, 4'hF);
    for (int k = 0; k < 4; k++) begin
      chk("bvalid_hold_aw_first", 32'(bvalid), 32'h1);
      tick();
    end
    bready = 1'b1;
    drain();
    bready = 1'b0;
    cq0.push_back(8'h43);
    bq.push_back(OKAY);
    hs_w(32'h43, 4'hF);
    for (int k = 0; k < 3; k++) begin
      chk("bvalid_before_aw", 32'(bvalid), 32'h0);
      tick();
    end
    hs_aw(13'h1000);
    for (int k = 0; k < 4; k++) begin
      chk("bvalid_hold_w_first", 32'(bvalid), 32'h1);
      tick();
    end
    bready = 1'b1;
    drain();
    drain_chars();

    // Exit register
    axi_write(13'h1018, 32'hDEAD_0001, 4'hF, OKAY, 2'b00);
    chk("test_done_with_bvalid", 32'(test_done), 32'h1);
    chk("test_code", test_code, 32'hDEAD_0001);
    chk("test_channel", 32'(test_channel), 32'h1);
    drain();
    axi_write(13'h1008, 32'h5, 4'hF, OKAY, 2'b00);
    drain();
    chk("test_code_sticky", test_code, 32'hDEAD_0001);
    chk("test_channel_sticky", 32'({test_done, test_channel}), 32'h11);
    axi_read(13'h1008, 32'hDEAD_0001, OKAY);
    axi_read(13'h1000, 32'h0, OKAY);
    drain();

    // Decode errors, then confirm FIFOs untouched
    axi_write(13'h0000, 32'h55, 4'hF, DECERR, 2'b00);
    axi_read(13'h1020, 32'h0, DECERR);
    axi_read(13'h100C, 32'h0, DECERR);
    axi_read(13'h0004, 32'h0, DECERR);
    drain();
    axi_read(13'h1004, 32'h0000_0400, OKAY);
    axi_read(13'h1014, 32'h0000_0400, OKAY);
    drain();

    // Reset in the middle of a write
    char_ready = 2'b00;
    axi_write(13'h1000, 32'h77, 4'hF, OKAY, 2'b00);
    drain();
    chk("pre_reset_char0_valid", 32'(char_valid[0]), 32'h1);
    hs_aw(13'h1000);
    chk("mid_write_state", 32'({awready, wready}), 32'h1);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("post_reset_readies", 32'({awready, wready, arready}), 32'h7);
    chk("post_reset_bvalid", 32'({bvalid, rvalid}), 32'h0);
    chk("post_reset_fifos", 32'(char_valid), 32'h0);
    chk("post_reset_test_done", 32'(test_done), 32'h0);
    char_ready = 2'b01;
    cq0.push_back(8'h61);
    axi_write(13'h1000, 32'h61, 4'hF, OKAY, 2'b00);
    drain();
    drain_chars();

    chk("scoreboard_empty", 32'(bq.size() + rq.size() + cq0.size() + cq1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=time limit expected=finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axi_lite_sim_console.md
# axi_lite_sim_console

Parametrised AXI4-Lite console and test-exit peripheral for the cva5 simulation system. It replaces single-address UART write capture with a full slave on the processor's peripheral bus, decoded at 0x1000. It provides NUM_CHANNELS independent byte FIFOs, each drained by a ready/valid character stream to the bench's log writers. It also provides a per-channel exit register that ends a run with a status code.

## Interface
- NUM_CHANNELS, 2: console channels, 1..16
- FIFO_DEPTH, 16: bytes per channel FIFO, power of two, 2..256
- ADDR_W, 13: AXI address width; decode uses bits [12:0]
- clk  in  1  bus clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
- char_data  out  8*NUM_CHANNELS  head byte per channel, channel c at [8c+7:8c]
- char_valid  out  NUM_CHANNELS  channel FIFO non-empty
- char_ready  in  NUM_CHANNELS  consumer pops the head byte when valid&ready
- test_done  out  1  sticky; an exit register was written
- test_code  out  32  wdata of the first exit write
- test_channel  out  4  channel index of the first exit write

## Operation
- Decode:
  - addr[12] must be 1.
  - Channel = addr[11:4]; register = addr[3:2].
  - Any of the following is unmapped → resp DECERR (2'b11), no side effect, rdata 0: addr[12]=0, channel ≥ NUM_CHANNELS, or register 3.
- Register map per channel:
  - +0x0 TX (W): if wstrb[0], push wdata[7:0]. If wstrb[0]=0, nothing happens; resp OKAY. Read returns 0.
  - +0x4 STATUS (R): [8:0] occupancy, [9] full, [10] empty, [11] overflow sticky. Writes are ignored; resp OKAY.
  - +0x8 EXIT (W): first exit write in the system sets test_done and captures test_code and test_channel. Later exit writes are ignored; resp OKAY. Read returns test_code.
- Full FIFO:
  - A TX push to a full FIFO is dropped, overflow is set, and bresp is SLVERR (2'b10).
  - Exception: if the same channel pops in the same cycle, the push is accepted and resp is OKAY.
- Overflow clears when STATUS is read (at the ar handshake). If an overflow event occurs in that same cycle, overflow stays 1.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - awready=1 in IDLE and HAVE_W; wready=1 in IDLE and HAVE_AW.
  - Both handshakes may occur in the same cycle; AW and W may arrive in either order, and each is latched.
  - When both are held, the write executes in that cycle's state → RESP.
  - RESP holds bvalid until bready, then → IDLE.
- Read FSM states: IDLE, RESP.
  - arready=1 only in IDLE.
  - On handshake → RESP; rdata/rresp are registered and held until rready.
- STATUS reflects FIFO state as of the ar handshake cycle.
- Each FIFO has independent read and write pointers of log2(FIFO_DEPTH)+1 bits; full and empty are derived from wrap bits.

## Timing
- Reset (resetn=0 at an edge): all FIFOs empty; overflow 0; both FSMs IDLE.
- Output reset values:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - char_valid=0, char_data=0.
  - test_done=0, test_code=0, test_channel=0.
- Write latency: bvalid rises on the edge after the cycle in which both AW and W are held. The fastest cycle is 2 clocks per write with bready tied to 1.
- A pushed byte appears on char_valid/char_data on the same edge that raises bvalid.
- A pop updates char_data on the following edge.
- Read latency: rvalid rises on the edge after the ar handshake. Back-to-back reads cost 2 cycles each.
- test_done rises on the same edge as the exit write's bvalid and never falls except on reset.
- Reset asserted mid-transaction aborts it: no bvalid/rvalid is issued and FIFO contents are lost.
- Writes and reads proceed concurrently. A TX push and a STATUS read of the same channel in the same cycle return pre-push occupancy.

## Test plan
- Basic push/drain: write 0x41 to 0x1000 (channel 0 TX), char_ready=1 → bresp OKAY at +2 cycles; char_valid0 pulses once with data 0x41.
- Full and overflow, FIFO_DEPTH=16, char_ready=0:
  - 17 TX writes to channel 1 (0x1010) → writes 1–16 OKAY, write 17 SLVERR.
  - STATUS read (0x1014) → 0x0000_0A10 (occupancy 16, full, overflow).
  - A second STATUS read → overflow bit clear.
- Push while full with a simultaneous pop on the same channel → OKAY, occupancy stays 16, overflow stays 0.
- AW three cycles before W, then W before AW, with bready delayed 4 cycles → each write executes exactly once and bvalid holds until bready.
- Exit path: write 0xDEAD0001 to 0x1018, then 0x5 to 0x1008 → test_done=1, test_code=0xDEAD0001, test_channel=1; the second write does not change them.
- Decode errors: write to 0x0000 and read 0x1020 with NUM_CHANNELS=2 → DECERR, rdata 0, no FIFO change.
- Reset mid-write: deassert resetn after the AW handshake only → after release, FSMs are IDLE, bvalid=0, all FIFOs empty.
